// File: rtl/spike_fanout_scheduler.sv
// ---------------------------------------------------------------------------
// spike_fanout_scheduler
//
// Purpose:
//   Queues incoming spike events (source neuron tags) in a small FIFO and,
//   for each queued source, scans its row of the efferent weight matrix
//   across every destination tag. One synaptic event (dst_tag, weight) is
//   emitted per nonzero weight through a registered valid/ready output
//   stage; zero weights are skipped without costing an output slot.
//   A separate load mode walks the matrix in raster order and drives the
//   matrix write port from a valid/ready weight stream.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   spike_valid/_tag/_ready   spike event input (ready = queue not full)
//   load_start                pulse in IDLE to begin a full-matrix load
//   load_valid/_weight/_ready load weight stream (ready while loading)
//   load_done                 one-cycle pulse after the final load write
//   src_tag, dst_tag          matrix row / column select
//   write_en, weight_in       matrix write strobe / data
//   weight_out                matrix read data (combinational on the selects)
//   syn_valid/_ready          synaptic event handshake (registered output)
//   syn_dst, syn_weight       synaptic event payload (registered)
//   busy                      scanning/loading, queue non-empty or event pending
// ---------------------------------------------------------------------------
module spike_fanout_scheduler #(
    parameter int numwidth   = 16,
    parameter int tagbits    = 1,
    parameter int numneurons = 2,
    parameter int fifodepth  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spike_valid,
    input  logic [tagbits-1:0]  spike_tag,
    output logic                spike_ready,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [numwidth:0]   load_weight,
    output logic                load_ready,
    output logic                load_done,
    output logic [tagbits-1:0]  src_tag,
    output logic [tagbits-1:0]  dst_tag,
    output logic                write_en,
    output logic [numwidth:0]   weight_in,
    input  logic [numwidth:0]   weight_out,
    output logic                syn_valid,
    input  logic                syn_ready,
    output logic [tagbits-1:0]  syn_dst,
    output logic [numwidth:0]   syn_weight,
    output logic                busy
);

    localparam int ptrbits = (fifodepth > 1) ? $clog2(fifodepth) : 1;

    localparam logic [tagbits-1:0] last_tag = tagbits'(numneurons - 1);
    localparam logic [tagbits-1:0] tag_one  = tagbits'(1);
    localparam logic [ptrbits-1:0] ptr_one  = ptrbits'(1);
    localparam logic [ptrbits:0]   cnt_one  = (ptrbits + 1)'(1);
    localparam logic [ptrbits:0]   cnt_full = (ptrbits + 1)'(fifodepth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Spike queue
    logic [tagbits-1:0] fifo_mem [fifodepth];
    logic [ptrbits-1:0] wr_ptr_reg;
    logic [ptrbits-1:0] rd_ptr_reg;
    logic [ptrbits:0]   count_reg;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [tagbits-1:0] head;

    // Row / column counters (row only used by load; scan row is the queue head)
    logic [tagbits-1:0] row_reg, row_next;
    logic [tagbits-1:0] col_reg, col_next;

    // Output event register
    logic               syn_valid_reg, syn_valid_next;
    logic [tagbits-1:0] syn_dst_reg, syn_dst_next;
    logic [numwidth:0]  syn_weight_reg, syn_weight_next;
    logic               load_done_reg, load_done_next;

    logic               weight_zero;
    logic               out_free;

    assign fifo_full   = (count_reg == cnt_full);
    assign fifo_empty  = (count_reg == '0);
    assign push        = spike_valid && !fifo_full;
    assign head        = fifo_mem[rd_ptr_reg];
    assign spike_ready = !fifo_full;

    // Queue storage needs no reset: emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= spike_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_one;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_one;
            end
            // push is gated by !full, so a pop in the same cycle never
            // makes room for that push.
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + cnt_one;
                2'b01:   count_reg <= count_reg - cnt_one;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            syn_valid_reg  <= 1'b0;
            syn_dst_reg    <= '0;
            syn_weight_reg <= '0;
            load_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            syn_valid_reg  <= syn_valid_next;
            syn_dst_reg    <= syn_dst_next;
            syn_weight_reg <= syn_weight_next;
            load_done_reg  <= load_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        syn_valid_next  = syn_valid_reg;
        syn_dst_next    = syn_dst_reg;
        syn_weight_next = syn_weight_reg;
        load_done_next  = 1'b0;
        pop             = 1'b0;
        src_tag         = '0;
        dst_tag         = '0;
        write_en        = 1'b0;
        weight_in       = '0;
        load_ready      = 1'b0;
        weight_zero     = (weight_out == '0);
        out_free        = !syn_valid_reg || syn_ready;

        // Pending event consumed; a capture below in the same cycle overrides.
        if (syn_valid_reg && syn_ready) begin
            syn_valid_next = 1'b0;
        end

        unique case (state_reg)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                    row_next   = '0;
                    col_next   = '0;
                end else if (!fifo_empty) begin
                    state_next = SCAN;
                    col_next   = '0;
                end
            end

            SCAN: begin
                src_tag = head;
                dst_tag = col_reg;
                // Zero weights always advance; nonzero ones wait for a free
                // output register so nothing is overwritten while held.
                if (weight_zero || out_free) begin
                    if (!weight_zero) begin
                        syn_valid_next  = 1'b1;
                        syn_dst_next    = col_reg;
                        syn_weight_next = weight_out;
                    end
                    if (col_reg == last_tag) begin
                        pop      = 1'b1;
                        col_next = '0;
                        // Another spike already queued: start its row next
                        // cycle without returning through IDLE.
                        if (count_reg > cnt_one) begin
                            state_next = SCAN;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        col_next = col_reg + tag_one;
                    end
                end
            end

            LOAD: begin
                load_ready = 1'b1;
                src_tag    = row_reg;
                dst_tag    = col_reg;
                weight_in  = load_weight;
                write_en   = load_valid;
                if (load_valid) begin
                    if (col_reg == last_tag) begin
                        col_next = '0;
                        if (row_reg == last_tag) begin
                            row_next       = '0;
                            state_next     = IDLE;
                            load_done_next = 1'b1;
                        end else begin
                            row_next = row_reg + tag_one;
                        end
                    end else begin
                        col_next = col_reg + tag_one;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign syn_valid  = syn_valid_reg;
    assign syn_dst    = syn_dst_reg;
    assign syn_weight = syn_weight_reg;
    assign load_done  = load_done_reg;
    assign busy       = (state_reg != IDLE) || !fifo_empty || syn_valid_reg;

endmodule
